branch_predictor: RTL and testbench

- Dynamic branch predictor feeding the fetch-stage next-PC selector.
- Fetch side: combinational lookup on PCF_i drives PredictTakenF_o / PredictTargetF_o.
- Execute side: resolves the in-flight prediction, raises MispredictE_o, and trains a direct-mapped BTB of 2-bit saturating counters.
- Sits between IF (lookup) and EX (resolution). The next-PC selector consumes its outputs together with PCSrcE_i / PCPlus4E.

---
 rtl/branch_predictor.sv | 181 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB of 2-bit saturating counters.
// Fetch side does a zero-latency lookup on PCF_i; execute side resolves the
// in-flight prediction, flags redirects and trains the table.
module branch_predictor #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ENTRIES    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    // Fetch-stage lookup
    input  logic [DATA_WIDTH-1:0] PCF_i,
    output logic                  PredictTakenF_o,
    output logic [DATA_WIDTH-1:0] PredictTargetF_o,

    // Execute-stage resolution
    input  logic                  ValidE_i,
    input  logic                  BranchE_i,
    input  logic                  JalrE_i,
    input  logic [DATA_WIDTH-1:0] PCE_i,
    input  logic                  PCSrcE_i,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    input  logic [DATA_WIDTH-1:0] ALUResultE_i,
    input  logic                  PredictTakenE_i,
    input  logic [DATA_WIDTH-1:0] PredictTargetE_i,
    output logic                  MispredictE_o,

    // Statistics
    output logic [31:0]           BranchCount_o,
    output logic [31:0]           MispredictCount_o
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = DATA_WIDTH - IDX - 2;

    localparam logic [1:0] CtrSn = 2'b00;
    localparam logic [1:0] CtrWn = 2'b01;
    localparam logic [1:0] CtrWt = 2'b10;
    localparam logic [1:0] CtrSt = 2'b11;

    localparam logic [31:0] StatMax = 32'hFFFF_FFFF;

    // BTB storage
    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];

    // Statistics registers
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    // Fetch-side decode
    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    // Execute-side decode
    logic [IDX-1:0]        e_idx;
    logic [TAG_W-1:0]      e_tag;
    logic                  e_hit;
    logic [DATA_WIDTH-1:0] actual_target;
    logic                  mispredict;

    // Write port into the entry selected by PCE_i
    logic                  wr_en;
    logic                  wr_valid;
    logic [TAG_W-1:0]      wr_tag;
    logic [DATA_WIDTH-1:0] wr_target;
    logic [1:0]            wr_ctr;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CtrSt) ? CtrSt : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CtrSn) ? CtrSn : c - 2'd1;
    endfunction

    // Fetch lookup; reads pre-update contents, no write bypass
    always_comb begin
        f_idx = PCF_i[IDX+1:2];
        f_tag = PCF_i[DATA_WIDTH-1:IDX+2];
        f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

        PredictTakenF_o  = f_hit && ctr_q[f_idx][1];
        PredictTargetF_o = PredictTakenF_o ? target_q[f_idx] : '0;
    end

    // Resolution: actual target and redirect decision
    always_comb begin
        e_idx = PCE_i[IDX+1:2];
        e_tag = PCE_i[DATA_WIDTH-1:IDX+2];
        e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

        actual_target = JalrE_i ? ALUResultE_i : PCTargetE_i;

        // Also catches a non-control instruction that aliased onto a taken entry
        mispredict = ValidE_i &&
                     ((PredictTakenE_i != PCSrcE_i) ||
                      (PCSrcE_i && PredictTakenE_i && (PredictTargetE_i != actual_target)));
        MispredictE_o = mispredict;
    end

    // Training: work out what to write into the resolved entry
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid_q[e_idx];
        wr_tag    = tag_q[e_idx];
        wr_target = target_q[e_idx];
        wr_ctr    = ctr_q[e_idx];

        if (ValidE_i) begin
            if (BranchE_i) begin
                if (e_hit) begin
                    wr_en  = 1'b1;
                    wr_ctr = PCSrcE_i ? ctr_inc(ctr_q[e_idx]) : ctr_dec(ctr_q[e_idx]);
                    if (PCSrcE_i) begin
                        wr_target = actual_target;
                    end
                end else if (PCSrcE_i) begin
                    // Allocate over whatever lives here, starting weakly taken
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_tag    = e_tag;
                    wr_target = actual_target;
                    wr_ctr    = CtrWt;
                end
            end else if (e_hit) begin
                // Non-control instruction matched an entry: purge the alias
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    // Saturating statistics next-state
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (ValidE_i && BranchE_i && (branch_cnt_q != StatMax)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict && (mispred_cnt_q != StatMax)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // BTB state; reset clears valid and parks every counter at weakly not-taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CtrWn;
            end
        end else if (wr_en) begin
            valid_q[e_idx]  <= wr_valid;
            tag_q[e_idx]    <= wr_tag;
            target_q[e_idx] <= wr_target;
            ctr_q[e_idx]    <= wr_ctr;
        end
    end

    // Statistics registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCount_o     = branch_cnt_q;
    assign MispredictCount_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a queue-based scoreboard.
module tb_branch_predictor;

    localparam int unsigned DW = 32;

    localparam int SelTaken  = 0;
    localparam int SelTarget = 1;
    localparam int SelMis    = 2;
    localparam int SelBcnt   = 3;
    localparam int SelMcnt   = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] pcf;
    logic          pred_taken_f;
    logic [DW-1:0] pred_target_f;
    logic          valid_e;
    logic          branch_e;
    logic          jalr_e;
    logic [DW-1:0] pce;
    logic          pcsrc_e;
    logic [DW-1:0] pctarget_e;
    logic [DW-1:0] aluresult_e;
    logic          pred_taken_e;
    logic [DW-1:0] pred_target_e;
    logic          mispredict_e;
    logic [31:0]   branch_count;
    logic [31:0]   mispredict_count;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int vectors;
    int miscompares;

    branch_predictor #(
        .DATA_WIDTH(DW),
        .ENTRIES   (16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .PCF_i            (pcf),
        .PredictTakenF_o  (pred_taken_f),
        .PredictTargetF_o (pred_target_f),
        .ValidE_i         (valid_e),
        .BranchE_i        (branch_e),
        .JalrE_i          (jalr_e),
        .PCE_i            (pce),
        .PCSrcE_i         (pcsrc_e),
        .PCTargetE_i      (pctarget_e),
        .ALUResultE_i     (aluresult_e),
        .PredictTakenE_i  (pred_taken_e),
        .PredictTargetE_i (pred_target_e),
        .MispredictE_o    (mispredict_e),
        .BranchCount_o    (branch_count),
        .MispredictCount_o(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SelTaken:  return {31'd0, pred_taken_f};
            SelTarget: return pred_target_f;
            SelMis:    return {31'd0, mispredict_e};
            SelBcnt:   return branch_count;
            default:   return mispredict_count;
        endcase
    endfunction

    task automatic check_all();
        sb_item_t it;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            obs = observe(it.sel);
            vectors++;
            assert (obs === it.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
            end
        end
    endtask

    // Check combinational outputs mid-cycle, then let the clock edge commit
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_e();
        valid_e       = 1'b0;
        branch_e      = 1'b0;
        jalr_e        = 1'b0;
        pce           = '0;
        pcsrc_e       = 1'b0;
        pctarget_e    = '0;
        aluresult_e   = '0;
        pred_taken_e  = 1'b0;
        pred_target_e = '0;
    endtask

    task automatic resolve(input logic [DW-1:0] pc, input logic br, input logic jalr,
                           input logic taken, input logic [DW-1:0] tgt,
                           input logic [DW-1:0] alu, input logic ptaken,
                           input logic [DW-1:0] ptgt);
        valid_e       = 1'b1;
        branch_e      = br;
        jalr_e        = jalr;
        pce           = pc;
        pcsrc_e       = taken;
        pctarget_e    = tgt;
        aluresult_e   = alu;
        pred_taken_e  = ptaken;
        pred_target_e = ptgt;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        pcf         = 32'h100;
        idle_e();

        // Reset state
        push("rst_taken", SelTaken, 0);
        push("rst_target", SelTarget, 0);
        push("rst_mis", SelMis, 0);
        push("rst_bcnt", SelBcnt, 0);
        push("rst_mcnt", SelMcnt, 0);
        step();
        rst_n = 1'b1;

        // Cold taken branch allocates; same-cycle lookup still sees a miss
        resolve(32'h100, 1, 0, 1, 32'h80, 32'h0, 0, 32'h0);
        push("cold_mis", SelMis, 1);
        push("cold_same_cycle_taken", SelTaken, 0);
        step();
        idle_e();
        push("cold_next_taken", SelTaken, 1);
        push("cold_next_target", SelTarget, 32'h80);
        push("cold_bcnt", SelBcnt, 1);
        push("cold_mcnt", SelMcnt, 1);
        push("idle_mis", SelMis, 0);
        step();

        // Hysteresis: WT -> not taken -> WN
        resolve(32'h100, 1, 0, 0, 32'h80, 32'h0, 1, 32'h80);
        push("hyst_nt_mis", SelMis, 1);
        push("hyst_nt_old_taken", SelTaken, 1);
        step();
        resolve(32'h100, 1, 0, 1, 32'h80, 32'h0, 0, 32'h0);
        push("hyst_wn_taken", SelTaken, 0);
        push("hyst_wn_target", SelTarget, 0);
        push("hyst_t1_mis", SelMis, 1);
        step();
        resolve(32'h100, 1, 0, 1, 32'h80, 32'h0, 1, 32'h80);
        push("hyst_wt_taken", SelTaken, 1);
        push("hyst_t2_mis", SelMis, 0);
        step();
        push("hyst_t3_mis", SelMis, 0);
        step();
        idle_e();
        push("hyst_st_taken", SelTaken, 1);
        push("hyst_st_target", SelTarget, 32'h80);
        push("hyst_bcnt", SelBcnt, 5);
        push("hyst_mcnt", SelMcnt, 3);
        step();
        // One not-taken from a saturated ST must leave it predicting taken
        resolve(32'h100, 1, 0, 0, 32'h80, 32'h0, 1, 32'h80);
        push("sat_nt_mis", SelMis, 1);
        step();
        idle_e();
        push("sat_still_taken", SelTaken, 1);
        push("sat_mcnt", SelMcnt, 4);
        step();

        // Alias: same index, different tag misses; non-control hit is purged
        pcf = 32'h140;
        push("alias_lookup_taken", SelTaken, 0);
        push("alias_lookup_target", SelTarget, 0);
        step();
        pcf = 32'h100;
        resolve(32'h100, 0, 0, 0, 32'h0, 32'h0, 1, 32'h80);
        push("alias_mis", SelMis, 1);
        step();
        idle_e();
        push("alias_purged_taken", SelTaken, 0);
        push("alias_bcnt", SelBcnt, 6);
        push("alias_mcnt", SelMcnt, 5);
        step();

        // ValidE=0: nothing happens regardless of the other E inputs
        resolve(32'h100, 1, 0, 1, 32'h80, 32'h0, 0, 32'h0);
        valid_e = 1'b0;
        push("bubble_mis", SelMis, 0);
        step();
        idle_e();
        push("bubble_taken", SelTaken, 0);
        push("bubble_bcnt", SelBcnt, 6);
        push("bubble_mcnt", SelMcnt, 5);
        step();

        // JALR target change: train 0x200 -> 0x300 to ST, then resolve to 0x340
        resolve(32'h200, 1, 0, 1, 32'h300, 32'h0, 0, 32'h0);
        step();
        resolve(32'h200, 1, 0, 1, 32'h300, 32'h0, 1, 32'h300);
        step();
        pcf = 32'h200;
        resolve(32'h200, 1, 1, 1, 32'h300, 32'h340, 1, 32'h300);
        push("jalr_mis", SelMis, 1);
        push("jalr_old_target", SelTarget, 32'h300);
        step();
        idle_e();
        push("jalr_new_taken", SelTaken, 1);
        push("jalr_new_target", SelTarget, 32'h340);
        push("jalr_bcnt", SelBcnt, 9);
        push("jalr_mcnt", SelMcnt, 7);
        step();

        // Cold not-taken branch does not allocate
        resolve(32'h104, 1, 0, 0, 32'h40, 32'h0, 0, 32'h0);
        push("nt_cold_mis", SelMis, 0);
        step();
        idle_e();
        pcf = 32'h104;
        push("nt_cold_taken", SelTaken, 0);
        push("nt_cold_bcnt", SelBcnt, 10);
        step();

        // Same-cycle read/write at 0x100: old prediction now, new one next cycle
        pcf = 32'h100;
        resolve(32'h100, 1, 0, 1, 32'h80, 32'h0, 0, 32'h0);
        push("rw_same_taken", SelTaken, 0);
        push("rw_same_mis", SelMis, 1);
        step();
        idle_e();
        push("rw_next_taken", SelTaken, 1);
        push("rw_next_target", SelTarget, 32'h80);
        push("rw_mcnt", SelMcnt, 8);
        step();

        // Asynchronous reset mid-stream clears everything without a clock edge
        rst_n = 1'b0;
        #1;
        push("arst_taken", SelTaken, 0);
        push("arst_target", SelTarget, 0);
        push("arst_bcnt", SelBcnt, 0);
        push("arst_mcnt", SelMcnt, 0);
        check_all();
        #1;
        rst_n = 1'b1;
        push("post_rst_taken", SelTaken, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
